// File: rtl/led_pwm_bank_if.sv
// Timebase, config and LED-drive bundle of led_pwm_bank.
// master = timebase plus config source, slave = the PWM bank itself.
interface led_pwm_bank_if #(
  parameter int NCH      = 3,
  parameter int PWM_BITS = 8
);
  logic                    tick;
  logic [2*NCH-1:0]        cfg_mode;
  logic [PWM_BITS*NCH-1:0] cfg_level;
  logic                    cfg_load;
  logic                    cfg_pending;
  logic                    frame_o;
  logic [NCH-1:0]          pwm_o;

  modport master (
    output tick, cfg_mode, cfg_level, cfg_load,
    input  cfg_pending, frame_o, pwm_o
  );

  modport slave (
    input  tick, cfg_mode, cfg_level, cfg_load,
    output cfg_pending, frame_o, pwm_o
  );
endinterface

// File: rtl/led_pwm_bank.sv
// Multi-channel LED PWM driver: OFF/ON/BLINK/BREATHE with config applied only at frame wraps.
// Define LED_PWM_GAMMA_EN to square the duty (perceptual fade) at one extra cycle of latency.
module led_pwm_bank #(
  parameter int NCH        = 3,
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  led_pwm_bank_if.slave bus
);
  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  localparam int                  DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ZERO = DIV_W'(32'd0);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(32'd1);
  localparam logic [PWM_BITS-1:0] CTR_MAX  = PWM_BITS'((64'd1 << PWM_BITS) - 64'd1);
  localparam logic [PWM_BITS-1:0] LVL_ZERO = PWM_BITS'(32'd0);
  localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(32'd1);
  localparam logic                POL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NCH-1:0]      PWM_IDLE = {NCH{POL}};

  logic [PWM_BITS-1:0]           ctr_q, ctr_d;
  logic [DIV_W-1:0]              fdiv_q, fdiv_d;
  logic                          phase_q, phase_d;
  logic                          pending_q, pending_d;
  logic                          frame_q, frame_d;
  logic [NCH-1:0][1:0]           sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [NCH-1:0][PWM_BITS-1:0]  sh_lvl_q, sh_lvl_d, act_lvl_q, act_lvl_d;
  logic [NCH-1:0][PWM_BITS-1:0]  ramp_q, ramp_d;
  logic [NCH-1:0]                dir_q, dir_d;
  logic [NCH-1:0]                pwm_q, pwm_d;
  logic                          wrap_s, step_s, apply_s;

  function automatic logic [PWM_BITS-1:0] duty_f(input logic [1:0]          mode,
                                                 input logic [PWM_BITS-1:0] lvl,
                                                 input logic [PWM_BITS-1:0] ramp,
                                                 input logic                phase);
    logic [PWM_BITS-1:0] d;
    case (mode)
      MODE_OFF:     d = LVL_ZERO;
      MODE_ON:      d = lvl;
      MODE_BLINK:   d = phase ? lvl : LVL_ZERO;
      MODE_BREATHE: d = ramp;
      default:      d = LVL_ZERO;
    endcase
    return d;
  endfunction

`ifdef LED_PWM_GAMMA_EN
  logic [PWM_BITS-1:0]          ctr_p_q, ctr_p_d;
  logic [NCH-1:0][PWM_BITS-1:0] gduty_q, gduty_d;

  function automatic logic [PWM_BITS-1:0] gamma_f(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] p;
    p = (2*PWM_BITS)'(d) * (2*PWM_BITS)'(d);
    return p[2*PWM_BITS-1:PWM_BITS];
  endfunction
`endif

  assign wrap_s  = bus.tick && (ctr_q == CTR_MAX);
  assign step_s  = wrap_s && (fdiv_q == DIV_LAST);
  // A load in the wrap cycle sees pending_q from before the load, so it waits one more frame.
  assign apply_s = wrap_s && pending_q;

  // Next-state for counters, config shadow/active copies and breathe ramps.
  always_comb begin
    ctr_d      = ctr_q;
    fdiv_d     = fdiv_q;
    phase_d    = phase_q;
    pending_d  = pending_q;
    sh_mode_d  = sh_mode_q;
    sh_lvl_d   = sh_lvl_q;
    act_mode_d = act_mode_q;
    act_lvl_d  = act_lvl_q;
    ramp_d     = ramp_q;
    dir_d      = dir_q;
    frame_d    = wrap_s;

    if (bus.tick) ctr_d = ctr_q + LVL_ONE;
    else          ctr_d = ctr_q;

    if (wrap_s) fdiv_d = step_s ? DIV_ZERO : fdiv_q + DIV_ONE;
    else        fdiv_d = fdiv_q;

    if (step_s) phase_d = ~phase_q;
    else        phase_d = phase_q;

    if (bus.cfg_load) begin
      pending_d = 1'b1;
      sh_mode_d = bus.cfg_mode;
      sh_lvl_d  = bus.cfg_level;
    end else if (apply_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (apply_s) begin
      act_mode_d = sh_mode_q;
      act_lvl_d  = sh_lvl_q;
    end else begin
      act_mode_d = act_mode_q;
      act_lvl_d  = act_lvl_q;
    end

    for (int i = 0; i < NCH; i++) begin
      // dir_q: 1 = ramping down. Ramp is kept within [0, level] so it never wraps.
      if (step_s && (act_mode_q[i] == MODE_BREATHE)) begin
        if (act_lvl_q[i] == LVL_ZERO) begin
          ramp_d[i] = LVL_ZERO;
          dir_d[i]  = 1'b0;
        end else if (!dir_q[i]) begin
          ramp_d[i] = ramp_q[i] + LVL_ONE;
          dir_d[i]  = ((ramp_q[i] + LVL_ONE) == act_lvl_q[i]);
        end else begin
          ramp_d[i] = ramp_q[i] - LVL_ONE;
          dir_d[i]  = (ramp_q[i] != LVL_ONE);
        end
      end else begin
        ramp_d[i] = ramp_q[i];
        dir_d[i]  = dir_q[i];
      end

      if (apply_s) begin
        if (sh_mode_q[i] != MODE_BREATHE) begin
          ramp_d[i] = LVL_ZERO;
          dir_d[i]  = 1'b0;
        end else if (ramp_d[i] >= sh_lvl_q[i]) begin
          ramp_d[i] = sh_lvl_q[i];
          dir_d[i]  = (sh_lvl_q[i] != LVL_ZERO);
        end else begin
          ramp_d[i] = ramp_d[i];
          dir_d[i]  = dir_d[i];
        end
      end else if (act_mode_q[i] != MODE_BREATHE) begin
        ramp_d[i] = LVL_ZERO;
        dir_d[i]  = 1'b0;
      end else begin
        ramp_d[i] = ramp_d[i];
        dir_d[i]  = dir_d[i];
      end
    end
  end

`ifdef LED_PWM_GAMMA_EN
  // Gamma stage: square the duty and delay the counter alongside it.
  always_comb begin
    ctr_p_d = ctr_q;
    gduty_d = gduty_q;
    pwm_d   = pwm_q;
    for (int i = 0; i < NCH; i++) begin
      gduty_d[i] = gamma_f(duty_f(act_mode_q[i], act_lvl_q[i], ramp_q[i], phase_q));
      pwm_d[i]   = (ctr_p_q < gduty_q[i]) ^ POL;
    end
  end
`else
  // Linear compare against the duty of the current active config.
  always_comb begin
    pwm_d = pwm_q;
    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = (ctr_q < duty_f(act_mode_q[i], act_lvl_q[i], ramp_q[i], phase_q)) ^ POL;
    end
  end
`endif

  // State registers; reset drives LEDs inactive and drops any pending config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q      <= LVL_ZERO;
      fdiv_q     <= DIV_ZERO;
      phase_q    <= 1'b0;
      pending_q  <= 1'b0;
      frame_q    <= 1'b0;
      sh_mode_q  <= '0;
      sh_lvl_q   <= '0;
      act_mode_q <= '0;
      act_lvl_q  <= '0;
      ramp_q     <= '0;
      dir_q      <= '0;
      pwm_q      <= PWM_IDLE;
`ifdef LED_PWM_GAMMA_EN
      ctr_p_q    <= LVL_ZERO;
      gduty_q    <= '0;
`endif
    end else begin
      ctr_q      <= ctr_d;
      fdiv_q     <= fdiv_d;
      phase_q    <= phase_d;
      pending_q  <= pending_d;
      frame_q    <= frame_d;
      sh_mode_q  <= sh_mode_d;
      sh_lvl_q   <= sh_lvl_d;
      act_mode_q <= act_mode_d;
      act_lvl_q  <= act_lvl_d;
      ramp_q     <= ramp_d;
      dir_q      <= dir_d;
      pwm_q      <= pwm_d;
`ifdef LED_PWM_GAMMA_EN
      ctr_p_q    <= ctr_p_d;
      gduty_q    <= gduty_d;
`endif
    end
  end

  assign bus.cfg_pending = pending_q;
  assign bus.frame_o     = frame_q;
  assign bus.pwm_o       = pwm_q;
endmodule
